multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle control unit that sequences the shared register-file / ALU / data-memory datapath one instruction at a time. It latches the fetched instruction, steps through FETCH, DECODE, EXEC, MEM and WB, and drives every datapath select and write-enable (RegWrite, ALUSrc, ResultSrc, MemWrite, ALUControl, jalmuxSel) plus PC and instruction-register enables. Data-memory accesses use a req/ready handshake, so the controller tolerates wait-stated memory.

## Interface
- INSTR_WIDTH, 32, instruction word width
- ADDRESS_WIDTH, 5, register-index width (rd field)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  INSTR_WIDTH  fetched instruction word, sampled in FETCH
- eq  in  1  ALU Zero flag, sampled in EXEC for branches
- mem_ready  in  1  data memory accepted/completed the access this cycle
- ir_en  out  1  instruction-register load enable
- RegWrite  out  1  register-file write enable
- ALUSrc  out  1  0 = rs2, 1 = ImmOp
- ResultSrc  out  1  0 = ALU result, 1 = ReadData
- MemWrite  out  1  data-memory write enable
- mem_req  out  1  data-memory access request
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or
- jalmuxSel  out  1  write-back selects PC+4
- PCWrite  out  1  PC register load enable
- PCSrc  out  1  0 = PC+4, 1 = PC+ImmOp
- retire  out  1  one-cycle pulse on each instruction's final cycle

## Operation
- Supported: ADDI, ADD, SUB, AND, OR, LW, SW, BEQ, BNE, JAL. Anything else is illegal.
- FETCH: ir_en=1; instr latched into the internal IR at the clock edge; next state DECODE.
- DECODE: decode the IR into an op class, rd and funct fields. Register the result. Next state EXEC.
- EXEC, ALU ops: ALUSrc=1 for ADDI and LW/SW, 0 for R-type. ALUControl per op (add for ADDI/LW/SW). Next state WB (ALU ops) or MEM (LW/SW).
- EXEC, BEQ/BNE: ALUControl=001. PCWrite=1, retire=1. PCSrc=1 if taken (BEQ: eq=1, BNE: eq=0), else 0. Next state FETCH.
- EXEC, JAL: RegWrite=1 (unless rd=0), jalmuxSel=1, PCWrite=1, PCSrc=1, retire=1. Next state FETCH.
- MEM: mem_req=1. MemWrite=1 for SW. ALUControl=000 and ALUSrc=1 are held. Stay in MEM while mem_ready=0.
  - On mem_ready=1, LW goes to WB.
  - On mem_ready=1, SW asserts PCWrite=1, PCSrc=0, retire=1 that cycle and goes to FETCH.
- WB: RegWrite=1 (unless rd=0), ResultSrc=1 for LW, ALU controls held from EXEC, PCWrite=1, PCSrc=0, retire=1. Next state FETCH.
- RegWrite is always suppressed when rd=0.
- Any output not listed for a state is 0.

## Timing
- All outputs are Moore-decoded from registered state and IR fields. Exceptions with a combinational input path:
  - PCSrc depends on eq in EXEC.
  - PCWrite and retire depend on mem_ready in MEM.
- Cycles per instruction:
  - ALU ops: 4.
  - LW: 5 + wait cycles.
  - SW: 4 + wait cycles.
  - BEQ/BNE and JAL: 3.
- Handshake: mem_req and MemWrite stay high and stable from MEM entry until the cycle mem_ready=1. The access commits on that edge, and mem_req drops the next cycle. mem_ready outside MEM is ignored.
- Reset, including mid-instruction: state=FETCH, IR=0, all outputs 0. A pending store is abandoned with no write. The first FETCH occurs on the first edge after rst_n rises.

## Configuration
- MULTICYCLE_CTRL_TRAP_EN defined:
  - An illegal opcode in DECODE goes to state TRAP, which is terminal until reset.
  - In TRAP, output illegal=1 (extra 1-bit port) and all enables are 0.
- MULTICYCLE_CTRL_TRAP_EN undefined:
  - Illegal opcodes retire as NOPs: DECODE goes to WB with RegWrite forced 0, PCWrite=1, PCSrc=0.
  - No illegal port.

## Structure
- Shared package ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, WB, TRAP);
  - ALUControl encoding constants;
  - opcode/funct3/funct7 constants;
  - op-class enum.
- Sub-module instr_decode: purely combinational mapping from IR to {op class, rd, illegal}, instantiated once.

## Test plan
- ADDI x1,x0,5 (0x00500093) → ir_en in cycle 0, ALUSrc=1/ALUControl=000 in cycle 2, RegWrite=1 and retire in cycle 3, PCWrite in cycle 3.
- LW x2,0(x1) with mem_ready low for 2 cycles → mem_req high 3 cycles, WB with ResultSrc=1 and RegWrite=1, retire at cycle 6.
- SW x2,4(x1) with mem_ready immediate → MemWrite=mem_req=1 for exactly 1 cycle, RegWrite never asserted, retire at cycle 3.
- BEQ with eq=1, then BNE with eq=1 → first gives PCSrc=1 with PCWrite; second gives PCSrc=0 with PCWrite; each retires in 3 cycles.
- JAL x0 and ADD x0 → RegWrite stays 0; JAL still gives jalmuxSel=1 and PCSrc=1.
- rst_n pulsed low during a SW MEM wait → MemWrite/mem_req drop asynchronously; after release, ir_en asserts on the first cycle. With TRAP_EN, opcode 0x7F → illegal=1 held, no further ir_en.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states, op classes,
// ALUControl codes and RV32I opcode/funct constants.
package ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  typedef enum logic [3:0] {
    OpAddi,
    OpAdd,
    OpSub,
    OpAnd,
    OpOr,
    OpLw,
    OpSw,
    OpBeq,
    OpBne,
    OpJal,
    OpIllegal
  } op_class_e;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;

  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;
  localparam logic [6:0] OpcJal    = 7'b1101111;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Word   = 3'b010;
  localparam logic [2:0] F3Beq    = 3'b000;
  localparam logic [2:0] F3Bne    = 3'b001;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Sub  = 7'b0100000;

  // Branches compare via subtraction; loads, stores and ADDI compute an address/sum.
  function automatic logic [2:0] alu_ctrl(input op_class_e op);
    case (op)
      OpSub, OpBeq, OpBne: return AluSub;
      OpAnd:               return AluAnd;
      OpOr:                return AluOr;
      default:             return AluAdd;
    endcase
  endfunction

  function automatic logic uses_imm(input op_class_e op);
    return (op == OpAddi) || (op == OpLw) || (op == OpSw);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: maps the instruction register to an op class,
// destination register index and illegal flag.
module instr_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH   = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic [INSTR_WIDTH-1:0]   i_instr,
  output op_class_e                o_op,
  output logic [ADDRESS_WIDTH-1:0] o_rd,
  output logic                     o_illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused_bits;

  assign w_opcode      = i_instr[6:0];
  assign w_funct3      = i_instr[14:12];
  assign w_funct7      = i_instr[31:25];
  assign o_rd          = i_instr[7 +: ADDRESS_WIDTH];
  // Register-source and immediate fields feed the datapath, not the controller.
  assign w_unused_bits = ^i_instr[24:15];

  always_comb begin
    o_op = OpIllegal;
    case (w_opcode)
      OpcOpImm: if (w_funct3 == F3AddSub) o_op = OpAddi;
      OpcOp: begin
        case ({w_funct7, w_funct3})
          {F7Base, F3AddSub}: o_op = OpAdd;
          {F7Sub,  F3AddSub}: o_op = OpSub;
          {F7Base, F3And}:    o_op = OpAnd;
          {F7Base, F3Or}:     o_op = OpOr;
          default:            o_op = OpIllegal;
        endcase
      end
      OpcLoad:  if (w_funct3 == F3Word) o_op = OpLw;
      OpcStore: if (w_funct3 == F3Word) o_op = OpSw;
      OpcBranch: begin
        if (w_funct3 == F3Beq)      o_op = OpBeq;
        else if (w_funct3 == F3Bne) o_op = OpBne;
      end
      OpcJal:   o_op = OpJal;
      default:  o_op = OpIllegal;
    endcase
  end

  assign o_illegal = (o_op == OpIllegal);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB controller with a req/ready data-memory handshake.
// Define MULTICYCLE_CTRL_TRAP_EN to trap on illegal opcodes (adds the illegal port).
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH   = 32,
  parameter int unsigned ADDRESS_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   eq,
  input  logic                   mem_ready,
  output logic                   ir_en,
  output logic                   RegWrite,
  output logic                   ALUSrc,
  output logic                   ResultSrc,
  output logic                   MemWrite,
  output logic                   mem_req,
  output logic [2:0]             ALUControl,
  output logic                   jalmuxSel,
  output logic                   PCWrite,
  output logic                   PCSrc,
  output logic                   retire
`ifdef MULTICYCLE_CTRL_TRAP_EN
  ,
  output logic                   illegal
`endif
);

  state_e                   r_state;
  state_e                   w_state_next;
  logic [INSTR_WIDTH-1:0]   r_ir;
  op_class_e                r_op;
  logic [ADDRESS_WIDTH-1:0] r_rd;

  op_class_e                w_op;
  logic [ADDRESS_WIDTH-1:0] w_rd;
  logic                     w_illegal;
  logic                     w_rd_nz;

  instr_decode #(
    .INSTR_WIDTH  (INSTR_WIDTH),
    .ADDRESS_WIDTH(ADDRESS_WIDTH)
  ) u_instr_decode (
    .i_instr  (r_ir),
    .o_op     (w_op),
    .o_rd     (w_rd),
    .o_illegal(w_illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFetch;
      r_ir    <= '0;
      r_op    <= OpIllegal;
      r_rd    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StFetch) r_ir <= instr;
      if (r_state == StDecode) begin
        r_op <= w_op;
        r_rd <= w_rd;
      end
    end
  end

  assign w_rd_nz = (r_rd != '0);

  always_comb begin
    w_state_next = r_state;
    ir_en        = 1'b0;
    RegWrite     = 1'b0;
    ALUSrc       = 1'b0;
    ResultSrc    = 1'b0;
    MemWrite     = 1'b0;
    mem_req      = 1'b0;
    ALUControl   = AluAdd;
    jalmuxSel    = 1'b0;
    PCWrite      = 1'b0;
    PCSrc        = 1'b0;
    retire       = 1'b0;
`ifdef MULTICYCLE_CTRL_TRAP_EN
    illegal      = 1'b0;
`endif

    case (r_state)
      StFetch: begin
        ir_en        = 1'b1;
        w_state_next = StDecode;
      end

      StDecode: begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
        w_state_next = w_illegal ? StTrap : StExec;
`else
        // Illegal opcodes skip EXEC and retire from WB as a NOP.
        w_state_next = w_illegal ? StWb : StExec;
`endif
      end

      StExec: begin
        case (r_op)
          OpAddi, OpAdd, OpSub, OpAnd, OpOr: begin
            ALUSrc       = uses_imm(r_op);
            ALUControl   = alu_ctrl(r_op);
            w_state_next = StWb;
          end
          OpLw, OpSw: begin
            ALUSrc       = 1'b1;
            ALUControl   = AluAdd;
            w_state_next = StMem;
          end
          OpBeq, OpBne: begin
            ALUControl   = AluSub;
            PCWrite      = 1'b1;
            PCSrc        = (r_op == OpBeq) ? eq : ~eq;
            retire       = 1'b1;
            w_state_next = StFetch;
          end
          OpJal: begin
            RegWrite     = w_rd_nz;
            jalmuxSel    = 1'b1;
            PCWrite      = 1'b1;
            PCSrc        = 1'b1;
            retire       = 1'b1;
            w_state_next = StFetch;
          end
          default: w_state_next = StWb;
        endcase
      end

      StMem: begin
        mem_req    = 1'b1;
        MemWrite   = (r_op == OpSw);
        ALUSrc     = 1'b1;
        ALUControl = AluAdd;
        if (mem_ready) begin
          if (r_op == OpSw) begin
            PCWrite      = 1'b1;
            retire       = 1'b1;
            w_state_next = StFetch;
          end else begin
            w_state_next = StWb;
          end
        end
      end

      StWb: begin
        RegWrite     = w_rd_nz && (r_op != OpIllegal);
        ResultSrc    = (r_op == OpLw);
        ALUSrc       = uses_imm(r_op);
        ALUControl   = alu_ctrl(r_op);
        PCWrite      = 1'b1;
        retire       = 1'b1;
        w_state_next = StFetch;
      end

`ifdef MULTICYCLE_CTRL_TRAP_EN
      StTrap: begin
        illegal      = 1'b1;
        w_state_next = StTrap;
      end
`endif

      default: w_state_next = StFetch;
    endcase

    // Held in reset the state already reads FETCH; keep every output quiet until release.
    if (!rst_n) begin
      ir_en      = 1'b0;
      RegWrite   = 1'b0;
      ALUSrc     = 1'b0;
      ResultSrc  = 1'b0;
      MemWrite   = 1'b0;
      mem_req    = 1'b0;
      ALUControl = AluAdd;
      jalmuxSel  = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      retire     = 1'b0;
`ifdef MULTICYCLE_CTRL_TRAP_EN
      illegal    = 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; every cycle of each instruction is
// compared against a hand-built output vector.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        eq;
  logic        mem_ready;
  logic        ir_en, RegWrite, ALUSrc, ResultSrc, MemWrite, mem_req;
  logic [2:0]  ALUControl;
  logic        jalmuxSel, PCWrite, PCSrc, retire;
`ifdef MULTICYCLE_CTRL_TRAP_EN
  logic        illegal;
`endif

  int checks;
  int errors;

  multicycle_ctrl #(
    .INSTR_WIDTH  (32),
    .ADDRESS_WIDTH(5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .eq        (eq),
    .mem_ready (mem_ready),
    .ir_en     (ir_en),
    .RegWrite  (RegWrite),
    .ALUSrc    (ALUSrc),
    .ResultSrc (ResultSrc),
    .MemWrite  (MemWrite),
    .mem_req   (mem_req),
    .ALUControl(ALUControl),
    .jalmuxSel (jalmuxSel),
    .PCWrite   (PCWrite),
    .PCSrc     (PCSrc),
    .retire    (retire)
`ifdef MULTICYCLE_CTRL_TRAP_EN
    ,
    .illegal   (illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: ir_en RegWrite ALUSrc ResultSrc MemWrite mem_req ALUControl[2:0]
  //            jalmuxSel PCWrite PCSrc retire
  logic [12:0] w_outs;
  assign w_outs = {ir_en, RegWrite, ALUSrc, ResultSrc, MemWrite, mem_req, ALUControl,
                   jalmuxSel, PCWrite, PCSrc, retire};

  function automatic logic [12:0] mk(input logic ir, rw, as, rs, mw, mr,
                                     input logic [2:0] alu,
                                     input logic jm, pw, ps, rt);
    return {ir, rw, as, rs, mw, mr, alu, jm, pw, ps, rt};
  endfunction

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk_now(input string tag, input logic [12:0] exp);
    #1;
    check(tag, w_outs, exp);
  endtask

  task automatic chk_cycle(input string tag, input logic [12:0] exp);
    chk_now(tag, exp);
    @(negedge clk);
  endtask

  logic [12:0] e_idle, e_fetch;

  initial begin
    checks    = 0;
    errors    = 0;
    e_idle    = mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    e_fetch   = mk(1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
    rst_n     = 1'b0;
    instr     = 32'h0;
    eq        = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_now("reset_quiet", e_idle);

    // ADDI x1,x0,5
    rst_n = 1'b1;
    instr = 32'h0050_0093;
    chk_cycle("addi_fetch", e_fetch);
    instr = 32'h0;
    chk_cycle("addi_decode", e_idle);
    chk_cycle("addi_exec", mk(0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    chk_cycle("addi_wb", mk(0, 1, 1, 0, 0, 0, 3'b000, 0, 1, 0, 1));

    // LW x2,0(x1) with two wait cycles; mem_ready outside MEM must be ignored
    instr     = 32'h0000_A103;
    mem_ready = 1'b1;
    chk_cycle("lw_fetch", e_fetch);
    chk_cycle("lw_decode", e_idle);
    chk_cycle("lw_exec", mk(0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    mem_ready = 1'b0;
    chk_cycle("lw_mem_wait1", mk(0, 0, 1, 0, 0, 1, 3'b000, 0, 0, 0, 0));
    chk_cycle("lw_mem_wait2", mk(0, 0, 1, 0, 0, 1, 3'b000, 0, 0, 0, 0));
    mem_ready = 1'b1;
    chk_cycle("lw_mem_ready", mk(0, 0, 1, 0, 0, 1, 3'b000, 0, 0, 0, 0));
    mem_ready = 1'b0;
    chk_cycle("lw_wb", mk(0, 1, 1, 1, 0, 0, 3'b000, 0, 1, 0, 1));

    // SW x2,4(x1) with immediate ready
    instr = 32'h0020_A223;
    chk_cycle("sw_fetch", e_fetch);
    chk_cycle("sw_decode", e_idle);
    chk_cycle("sw_exec", mk(0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    mem_ready = 1'b1;
    chk_cycle("sw_mem", mk(0, 0, 1, 0, 1, 1, 3'b000, 0, 1, 0, 1));
    mem_ready = 1'b0;

    // BEQ: PCSrc follows eq combinationally in EXEC
    instr = 32'h0000_0463;
    chk_cycle("beq_fetch", e_fetch);
    chk_cycle("beq_decode", e_idle);
    eq = 1'b0;
    chk_now("beq_exec_nt", mk(0, 0, 0, 0, 0, 0, 3'b001, 0, 1, 0, 1));
    eq = 1'b1;
    chk_cycle("beq_exec_t", mk(0, 0, 0, 0, 0, 0, 3'b001, 0, 1, 1, 1));

    // BNE with eq=1: not taken
    instr = 32'h0000_1463;
    chk_cycle("bne_fetch", e_fetch);
    chk_cycle("bne_decode", e_idle);
    chk_cycle("bne_exec", mk(0, 0, 0, 0, 0, 0, 3'b001, 0, 1, 0, 1));
    eq = 1'b0;

    // JAL x0: no register write
    instr = 32'h0080_006F;
    chk_cycle("jal0_fetch", e_fetch);
    chk_cycle("jal0_decode", e_idle);
    chk_cycle("jal0_exec", mk(0, 0, 0, 0, 0, 0, 3'b000, 1, 1, 1, 1));

    // JAL x1: link write
    instr = 32'h0080_00EF;
    chk_cycle("jal1_fetch", e_fetch);
    chk_cycle("jal1_decode", e_idle);
    chk_cycle("jal1_exec", mk(0, 1, 0, 0, 0, 0, 3'b000, 1, 1, 1, 1));

    // ADD x0,x1,x2: write suppressed
    instr = 32'h0020_8033;
    chk_cycle("add0_fetch", e_fetch);
    chk_cycle("add0_decode", e_idle);
    chk_cycle("add0_exec", mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    chk_cycle("add0_wb", mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 0, 1));

    // SUB x3,x1,x2
    instr = 32'h4020_81B3;
    chk_cycle("sub_fetch", e_fetch);
    chk_cycle("sub_decode", e_idle);
    chk_cycle("sub_exec", mk(0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0));
    chk_cycle("sub_wb", mk(0, 1, 0, 0, 0, 0, 3'b001, 0, 1, 0, 1));

    // AND x4,x1,x2
    instr = 32'h0020_F233;
    chk_cycle("and_fetch", e_fetch);
    chk_cycle("and_decode", e_idle);
    chk_cycle("and_exec", mk(0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0));
    chk_cycle("and_wb", mk(0, 1, 0, 0, 0, 0, 3'b010, 0, 1, 0, 1));

    // OR x5,x1,x2
    instr = 32'h0020_E2B3;
    chk_cycle("or_fetch", e_fetch);
    chk_cycle("or_decode", e_idle);
    chk_cycle("or_exec", mk(0, 0, 0, 0, 0, 0, 3'b011, 0, 0, 0, 0));
    chk_cycle("or_wb", mk(0, 1, 0, 0, 0, 0, 3'b011, 0, 1, 0, 1));

    // SW stalled in MEM, then asynchronous reset mid-wait
    instr = 32'h0020_A223;
    chk_cycle("swr_fetch", e_fetch);
    chk_cycle("swr_decode", e_idle);
    chk_cycle("swr_exec", mk(0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    chk_now("swr_mem_wait", mk(0, 0, 1, 0, 1, 1, 3'b000, 0, 0, 0, 0));
    #1;
    rst_n = 1'b0;
    chk_now("swr_async_reset", e_idle);
    @(negedge clk);
    chk_now("swr_held_reset", e_idle);
    rst_n = 1'b1;
    instr = 32'h0050_0093;
    chk_cycle("post_reset_fetch", e_fetch);
    instr = 32'h0;
    chk_cycle("post_reset_decode", e_idle);
    chk_cycle("post_reset_exec", mk(0, 0, 1, 0, 0, 0, 3'b000, 0, 0, 0, 0));
    chk_cycle("post_reset_wb", mk(0, 1, 1, 0, 0, 0, 3'b000, 0, 1, 0, 1));

    // Illegal opcode 0x7F with rd=1
    instr = 32'h0000_00FF;
    chk_cycle("ill_fetch", e_fetch);
    chk_cycle("ill_decode", e_idle);
`ifdef MULTICYCLE_CTRL_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      chk_now("trap_outputs", e_idle);
      checks++;
      assert (illegal === 1'b1)
      else begin
        errors++;
        $error("FAIL trap_illegal: observed %b expected 1", illegal);
      end
      @(negedge clk);
    end
`else
    chk_cycle("ill_nop_wb", mk(0, 0, 0, 0, 0, 0, 3'b000, 0, 1, 0, 1));
    chk_cycle("ill_next_fetch", e_fetch);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
